// File: rtl/sr_irq_ctl.sv
// Interrupt entry/exit sequencer: owns the special-register write bus, passes core
// writes through in IDLE, and inserts run-mode writes plus fetch redirects on irq/return.
module sr_irq_ctl #(
  parameter logic [15:0] VECTOR   = 16'h0010,
  parameter logic [1:0]  IRQ_MODE = 2'b01,
  parameter logic [6:0]  EXIT_OP  = 7'b0001111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic [15:0] pc,
  input  logic [6:0]  instr_op,
  input  logic        core_sr_we,
  input  logic [15:0] core_sr_sel,
  input  logic [15:0] core_sr_in,
  output logic        sr_ie,
  output logic [15:0] sr_sel,
  output logic [15:0] sr_in,
  output logic        hold,
  output logic        jump,
  output logic [15:0] jump_addr,
  output logic        irq_ack,
  input  logic [15:0] sr_rd_sel,
  output logic [15:0] sr_rd_data
);

  localparam logic [15:0] SelMode      = 16'h0001;
  localparam logic [15:0] SelIrqEn     = 16'h0008;
  localparam logic [15:0] SelSavedPc   = 16'h0010;
  localparam logic [15:0] SelSavedMode = 16'h0020;

  typedef enum logic [2:0] {StIdle, StEnterSr, StEnterJmp, StExitSr, StExitJmp} state_e;

  state_e      state_q, state_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] saved_pc_q, saved_pc_d;
  logic [1:0]  saved_mode_q, saved_mode_d;
  logic [1:0]  mode_shadow_q, mode_shadow_d;

  logic idle, exit_req, take_irq, idle_wr;

  assign idle     = (state_q == StIdle);
  assign exit_req = idle && (instr_op == EXIT_OP);
  // A core write in the same cycle defers entry so the write is not lost.
  assign take_irq = idle && !exit_req && irq && irq_en_q && !core_sr_we;
  assign idle_wr  = idle && core_sr_we;

  always_comb begin
    state_d   = state_q;
    sr_ie     = 1'b0;
    sr_sel    = 16'h0000;
    sr_in     = 16'h0000;
    jump      = 1'b0;
    jump_addr = 16'h0000;
    irq_ack   = 1'b0;
    hold      = 1'b0;
    if (!rst) begin
      hold = !idle;
      unique case (state_q)
        StIdle: begin
          sr_ie  = core_sr_we;
          sr_sel = core_sr_sel;
          sr_in  = core_sr_in;
          if (exit_req) begin
            state_d = StExitSr;
          end else if (take_irq) begin
            state_d = StEnterSr;
          end
        end
        StEnterSr: begin
          sr_ie   = 1'b1;
          sr_sel  = SelMode;
          sr_in   = {14'b0, IRQ_MODE};
          state_d = StEnterJmp;
        end
        StEnterJmp: begin
          jump      = 1'b1;
          jump_addr = VECTOR;
          irq_ack   = 1'b1;
          state_d   = StIdle;
        end
        StExitSr: begin
          sr_ie   = 1'b1;
          sr_sel  = SelMode;
          sr_in   = {14'b0, saved_mode_q};
          state_d = StExitJmp;
        end
        StExitJmp: begin
          jump      = 1'b1;
          jump_addr = saved_pc_q;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    irq_en_d      = irq_en_q;
    saved_pc_d    = saved_pc_q;
    saved_mode_d  = saved_mode_q;
    mode_shadow_d = mode_shadow_q;
    if (idle_wr && core_sr_sel == SelIrqEn)     irq_en_d     = core_sr_in[0];
    if (idle_wr && core_sr_sel == SelSavedPc)   saved_pc_d   = core_sr_in;
    if (idle_wr && core_sr_sel == SelSavedMode) saved_mode_d = core_sr_in[1:0];
    if (take_irq) begin
      saved_pc_d   = pc;
      saved_mode_d = mode_shadow_q;
      irq_en_d     = 1'b0;
    end
    if (state_q == StExitJmp) irq_en_d = 1'b1;
    // The file only accepts run-mode writes while bit 0 of the current mode is set.
    if (sr_ie && sr_sel == SelMode && mode_shadow_q[0]) mode_shadow_d = sr_in[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      irq_en_q      <= 1'b0;
      saved_pc_q    <= 16'h0000;
      saved_mode_q  <= 2'b01;
      mode_shadow_q <= 2'b01;
    end else begin
      state_q       <= state_d;
      irq_en_q      <= irq_en_d;
      saved_pc_q    <= saved_pc_d;
      saved_mode_q  <= saved_mode_d;
      mode_shadow_q <= mode_shadow_d;
    end
  end

  always_comb begin
    case (sr_rd_sel)
      SelIrqEn:     sr_rd_data = {14'b0, irq, irq_en_q};
      SelSavedPc:   sr_rd_data = saved_pc_q;
      SelSavedMode: sr_rd_data = {14'b0, saved_mode_q};
      default:      sr_rd_data = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_sr_irq_ctl.sv
// Directed bench for sr_irq_ctl: reset, entry/exit sequences, deferral, priority, mode shadow.
module tb_sr_irq_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  logic [15:0] pc;
  logic [6:0]  instr_op;
  logic        core_sr_we;
  logic [15:0] core_sr_sel;
  logic [15:0] core_sr_in;
  logic        sr_ie;
  logic [15:0] sr_sel;
  logic [15:0] sr_in;
  logic        hold;
  logic        jump;
  logic [15:0] jump_addr;
  logic        irq_ack;
  logic [15:0] sr_rd_sel;
  logic [15:0] sr_rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] ExitOp = 7'b0001111;

  sr_irq_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .pc         (pc),
    .instr_op   (instr_op),
    .core_sr_we (core_sr_we),
    .core_sr_sel(core_sr_sel),
    .core_sr_in (core_sr_in),
    .sr_ie      (sr_ie),
    .sr_sel     (sr_sel),
    .sr_in      (sr_in),
    .hold       (hold),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .irq_ack    (irq_ack),
    .sr_rd_sel  (sr_rd_sel),
    .sr_rd_data (sr_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    core_sr_we  = 1'b0;
    core_sr_sel = 16'h0000;
    core_sr_in  = 16'h0000;
    instr_op    = 7'd0;
  endtask

  task automatic wr(input logic [15:0] sel, input logic [15:0] data);
    core_sr_we  = 1'b1;
    core_sr_sel = sel;
    core_sr_in  = data;
    instr_op    = 7'd0;
  endtask

  initial begin
    logic bad;
    rst = 1'b1; irq = 1'b1; pc = 16'h0000; instr_op = 7'd0;
    core_sr_we = 1'b1; core_sr_sel = 16'h0001; core_sr_in = 16'h0005;
    sr_rd_sel = 16'h0008;
    #3;
    check("rst_sr_ie", {15'b0, sr_ie}, 16'h0000);
    check("rst_sr_sel", sr_sel, 16'h0000);
    check("rst_sr_in", sr_in, 16'h0000);
    check("rst_hold", {15'b0, hold}, 16'h0000);
    check("rst_rd_sel8", sr_rd_data, 16'h0002);
    tick(); tick();
    idle_in();
    rst = 1'b0;

    // irq with irq_en=0 must be ignored
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      bad = bad | hold | jump | irq_ack;
    end
    check("masked_irq_quiet", {15'b0, bad}, 16'h0000);
    check("masked_rd_sel8", sr_rd_data, 16'h0002);
    sr_rd_sel = 16'h0020; #1;
    check("rst_saved_mode", sr_rd_data, 16'h0001);

    // Enable, then interrupt at pc 0x0123
    tick(); irq = 1'b0; wr(16'h0008, 16'h0001); #1;
    check("pass_ie", {15'b0, sr_ie}, 16'h0001);
    check("pass_sel", sr_sel, 16'h0008);
    check("pass_in", sr_in, 16'h0001);
    tick(); idle_in(); pc = 16'h0123; irq = 1'b1; sr_rd_sel = 16'h0008; #1;
    check("en_rd", sr_rd_data, 16'h0003);
    check("entry_T_hold", {15'b0, hold}, 16'h0000);
    tick(); irq = 1'b0; #1;
    check("entry_T1_hold", {15'b0, hold}, 16'h0001);
    check("entry_T1_ie", {15'b0, sr_ie}, 16'h0001);
    check("entry_T1_sel", sr_sel, 16'h0001);
    check("entry_T1_in", sr_in, 16'h0001);
    check("entry_T1_jump", {15'b0, jump}, 16'h0000);
    tick(); #1;
    check("entry_T2_jump", {15'b0, jump}, 16'h0001);
    check("entry_T2_addr", jump_addr, 16'h0010);
    check("entry_T2_ack", {15'b0, irq_ack}, 16'h0001);
    check("entry_T2_ie", {15'b0, sr_ie}, 16'h0000);
    tick(); sr_rd_sel = 16'h0010; #1;
    check("entry_T3_hold", {15'b0, hold}, 16'h0000);
    check("saved_pc_123", sr_rd_data, 16'h0123);
    sr_rd_sel = 16'h0008; #1;
    check("entry_irq_en_off", sr_rd_data, 16'h0000);

    // Mode 2 set by core, interrupt, then return
    tick(); wr(16'h0001, 16'h0002);
    tick(); wr(16'h0008, 16'h0001);
    tick(); idle_in(); pc = 16'h0456; irq = 1'b1;
    tick(); irq = 1'b0;
    tick();
    tick(); instr_op = ExitOp; sr_rd_sel = 16'h0020; #1;
    check("saved_mode_2", sr_rd_data, 16'h0002);
    tick(); instr_op = 7'd0; #1;
    check("exit_T1_hold", {15'b0, hold}, 16'h0001);
    check("exit_T1_ie", {15'b0, sr_ie}, 16'h0001);
    check("exit_T1_sel", sr_sel, 16'h0001);
    check("exit_T1_in", sr_in, 16'h0002);
    tick(); sr_rd_sel = 16'h0008; #1;
    check("exit_T2_jump", {15'b0, jump}, 16'h0001);
    check("exit_T2_addr", jump_addr, 16'h0456);
    check("exit_T2_ack", {15'b0, irq_ack}, 16'h0000);
    check("exit_T2_en", sr_rd_data, 16'h0000);
    tick(); #1;
    check("exit_T3_en", sr_rd_data, 16'h0001);
    check("exit_T3_hold", {15'b0, hold}, 16'h0000);

    // irq coinciding with a core write is deferred one cycle
    tick(); irq = 1'b1; pc = 16'h0789; wr(16'h0002, 16'hABCD); #1;
    check("defer_pass_ie", {15'b0, sr_ie}, 16'h0001);
    check("defer_pass_sel", sr_sel, 16'h0002);
    check("defer_pass_in", sr_in, 16'hABCD);
    check("defer_T_hold", {15'b0, hold}, 16'h0000);
    tick(); idle_in(); #1;
    check("defer_T1_hold", {15'b0, hold}, 16'h0000);
    tick(); irq = 1'b0; #1;
    check("defer_T2_hold", {15'b0, hold}, 16'h0001);
    check("defer_T2_sel", sr_sel, 16'h0001);
    tick();
    tick();

    // irq together with EXIT_OP: exit wins, then immediate re-entry
    tick(); wr(16'h0008, 16'h0001);
    tick(); idle_in(); irq = 1'b1; instr_op = ExitOp;
    tick(); instr_op = 7'd0; #1;
    check("prio_exit_ie", {15'b0, sr_ie}, 16'h0001);
    check("prio_exit_in", sr_in, 16'h0002);
    tick(); #1;
    check("prio_exit_addr", jump_addr, 16'h0789);
    check("prio_exit_ack", {15'b0, irq_ack}, 16'h0000);
    tick(); #1;
    check("reentry_T_hold", {15'b0, hold}, 16'h0000);
    tick(); #1;
    check("reentry_T1_hold", {15'b0, hold}, 16'h0001);
    check("reentry_T1_in", sr_in, 16'h0001);

    // Reset during ENTER_SR
    rst = 1'b1; #1;
    check("midrst_ie", {15'b0, sr_ie}, 16'h0000);
    check("midrst_hold", {15'b0, hold}, 16'h0000);
    check("midrst_sel", sr_sel, 16'h0000);
    check("midrst_in", sr_in, 16'h0000);
    irq = 1'b0;
    tick(); rst = 1'b0; sr_rd_sel = 16'h0008; #1;
    check("postrst_en", sr_rd_data, 16'h0000);
    check("postrst_hold", {15'b0, hold}, 16'h0000);
    sr_rd_sel = 16'h0020; #1;
    check("postrst_mode", sr_rd_data, 16'h0001);
    tick(); #1;
    check("postrst_jump", {15'b0, jump}, 16'h0000);
    check("postrst_hold2", {15'b0, hold}, 16'h0000);

    // mode_shadow acceptance rule and non-one-hot selects
    tick(); wr(16'h0001, 16'h0000);
    tick(); wr(16'h0001, 16'h0003); #1;
    check("shadow_pass_in", sr_in, 16'h0003);
    tick(); wr(16'h0018, 16'hFFFF); #1;
    check("nonhot_pass_sel", sr_sel, 16'h0018);
    tick(); idle_in(); sr_rd_sel = 16'h0008; #1;
    check("nonhot_no_en", sr_rd_data, 16'h0000);
    sr_rd_sel = 16'h0018; #1;
    check("nonhot_rd", sr_rd_data, 16'h0000);
    tick(); wr(16'h0008, 16'h0001);
    tick(); idle_in(); irq = 1'b1; pc = 16'h0ABC;
    tick(); irq = 1'b0; wr(16'h0010, 16'hDEAD); #1;
    check("busy_core_sel", sr_sel, 16'h0001);
    check("busy_core_in", sr_in, 16'h0001);
    tick(); idle_in();
    tick(); sr_rd_sel = 16'h0020; #1;
    check("shadow_saved_mode", sr_rd_data, 16'h0000);
    sr_rd_sel = 16'h0010; #1;
    check("busy_saved_pc", sr_rd_data, 16'h0ABC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_irq_ctl.md
# sr_irq_ctl

Interrupt entry/exit sequencer that owns the initiator side of the special-register write bus (sr_ie/sr_sel/sr_in) feeding the special-register file. In normal operation it passes execute-stage SRS writes straight through. On an enabled interrupt it stalls the core, saves the return PC and run mode, forces the interrupt run mode, and redirects fetch to a fixed vector. On the return opcode it restores mode and PC. It also provides a read port for the registers it owns.

## Interface
- VECTOR, 16'h0010, handler entry address
- IRQ_MODE, 2'b01, run-mode value written to sr_sel 1 on interrupt entry
- EXIT_OP, 7'b0001111, instr_op value that triggers return from interrupt
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- irq  in  1  level interrupt request
- pc  in  16  address of next instruction to execute
- instr_op  in  7  opcode currently in execute
- core_sr_we  in  1  execute-stage special-register write strobe
- core_sr_sel  in  16  write select, one-hot
- core_sr_in  in  16  write data
- sr_ie  out  1  write strobe to special-register file
- sr_sel  out  16  write select to special-register file
- sr_in  out  16  write data to special-register file
- hold  out  1  stall fetch/execute
- jump  out  1  fetch redirect strobe
- jump_addr  out  16  redirect target
- irq_ack  out  1  one-cycle interrupt-taken pulse
- sr_rd_sel  in  16  read select
- sr_rd_data  out  16  read data, combinational

## Operation
- Local registers:
  - irq_en (1b): reset 0.
  - saved_pc (16b): reset 0.
  - saved_mode (2b): reset 2'b01.
  - mode_shadow (2b): reset 2'b01.
- mode_shadow tracks the file's run mode. On any cycle with sr_ie=1, sr_sel=16'h0001 and mode_shadow[0]=1, mode_shadow <= sr_in[1:0]. When mode_shadow[0]=0 the write is ignored, which mirrors the file's acceptance rule.
- FSM states: IDLE, ENTER_SR, ENTER_JMP, EXIT_SR, EXIT_JMP. hold = (state != IDLE).
- IDLE output drive:
  - sr_ie/sr_sel/sr_in = core_sr_we/core_sr_sel/core_sr_in, combinational passthrough.
  - Core writes to sel 16'h0008 load irq_en <= core_sr_in[0].
  - Core writes to sel 16'h0010 load saved_pc.
  - Core writes to sel 16'h0020 load saved_mode <= core_sr_in[1:0].
  - All of these writes are still forwarded on the bus.
- Transitions out of IDLE, checked in priority order:
  1. instr_op == EXIT_OP -> EXIT_SR.
  2. Otherwise, irq & irq_en & !core_sr_we -> ENTER_SR. On this edge: saved_pc <= pc, saved_mode <= mode_shadow, irq_en <= 0.
  3. An irq that coincides with a core write is deferred; it is taken on the next eligible IDLE cycle.
- ENTER_SR: drive sr_ie=1, sr_sel=16'h0001, sr_in={14'b0, IRQ_MODE}; next state ENTER_JMP.
- ENTER_JMP: drive jump=1, jump_addr=VECTOR, irq_ack=1; next state IDLE.
- EXIT_SR: drive sr_ie=1, sr_sel=16'h0001, sr_in={14'b0, saved_mode}; next state EXIT_JMP.
- EXIT_JMP: drive jump=1, jump_addr=saved_pc, irq_en <= 1; next state IDLE.
- Core writes presented in non-IDLE states are ignored. The core holds them under hold and re-presents them.
- Read port: sr_rd_data is
  - {14'b0, irq, irq_en} for sel 16'h0008,
  - saved_pc for 16'h0010,
  - {14'b0, saved_mode} for 16'h0020,
  - 0 otherwise, including non-one-hot selects.
- Non-one-hot write selects match no local register and are forwarded unchanged.

## Timing
- While rst=1:
  - sr_ie, jump, irq_ack, hold = 0.
  - sr_sel, sr_in, jump_addr = 0.
  - State is IDLE and all registers hold their reset values.
- Reset deasserted mid-sequence: the block restarts in IDLE with no partial write or jump issued.
- Entry latency: irq qualified in IDLE cycle T. sr write occurs in T+1, jump and irq_ack in T+2, IDLE again in T+3. hold=1 in T+1 and T+2.
- Exit latency: EXIT_OP in IDLE cycle T. Mode write occurs in T+1, jump to saved_pc in T+2, irq_en=1 visible from T+3.
- irq still high at T+3 with irq_en=1 (after an exit): a new entry starts immediately; there is no minimum gap.
- irq_en=0 during the handler, so nested interrupts are impossible unless software sets sel 16'h0008 bit 0.
- Passthrough in IDLE has zero latency. Local register updates from core writes are visible on sr_rd_data the next cycle.

## Test plan
- Reset, irq_en=0, irq=1 for 10 cycles -> no hold, jump or irq_ack; sr_rd_data(sel 8)=16'h0002.
- Core write sel 8 data 1, then pc=16'h0123 with irq=1 -> T+1: sr_ie=1, sel=1, in=16'h0001. T+2: jump=1, addr=16'h0010, irq_ack=1. Then saved_pc reads 16'h0123 and irq_en reads 0.
- Core writes sel 1 data 16'h0002, then interrupt, then EXIT_OP -> EXIT_SR drives sr_in=16'h0002. EXIT_JMP drives jump_addr=saved_pc. irq_en=1 afterwards.
- irq rises in the same cycle as core_sr_we=1 (sel 2) -> write is passed through and entry begins the next cycle. Second case: irq and EXIT_OP together -> exit sequence wins.
- Assert rst during ENTER_SR -> outputs drop to 0 asynchronously. After release: IDLE, irq_en=0, saved_mode=2'b01.
- mode_shadow check: write sel 1 data 16'h0000, then data 16'h0003 -> second write is ignored; a following interrupt saves saved_mode=2'b00.
